// File: rtl/vx_lane_packer_if.sv
// rtl/vx_lane_packer_if.sv - request/batch handshake bundle for the lane packer.
// slave is the packer's view; master is the driver/consumer view.
interface vx_lane_packer_if #(
    parameter int NUM_LANES = 8,
    parameter int OUT_LANES = 4,
    parameter int DATAW     = 32,
    parameter int TAGW      = 8,
    parameter int IDXW      = $clog2(NUM_LANES)
);
  logic                       valid_in;
  logic [NUM_LANES-1:0]       mask_in;
  logic [NUM_LANES*DATAW-1:0] data_in;
  logic [TAGW-1:0]            tag_in;
  logic                       ready_in;

  logic                       valid_out;
  logic [OUT_LANES-1:0]       mask_out;
  logic [OUT_LANES*DATAW-1:0] data_out;
  logic [OUT_LANES*IDXW-1:0]  idx_out;
  logic [TAGW-1:0]            tag_out;
  logic                       eop_out;
  logic                       ready_out;

  modport slave (
    input  valid_in, mask_in, data_in, tag_in, ready_out,
    output ready_in, valid_out, mask_out, data_out, idx_out, tag_out, eop_out
  );

  modport master (
    output valid_in, mask_in, data_in, tag_in, ready_out,
    input  ready_in, valid_out, mask_out, data_out, idx_out, tag_out, eop_out
  );
endinterface

// File: rtl/vx_lane_packer.sv
// rtl/vx_lane_packer.sv - compacts a sparse warp request into dense OUT_LANES batches.
// Optional feature macro: LANE_PACKER_SKIP_EMPTY_EN (drop mask==0 requests instead of emitting an empty batch).
module vx_lane_packer #(
    parameter int NUM_LANES = 8,
    parameter int OUT_LANES = 4,
    parameter int DATAW     = 32,
    parameter int TAGW      = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    vx_lane_packer_if.slave     bus
);
  localparam int IDXW = $clog2(NUM_LANES);
  localparam int CNTW = $clog2(NUM_LANES + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_LANES-1:0]       rem_q, rem_d;
  logic [NUM_LANES*DATAW-1:0] data_q, data_d;
  logic [TAGW-1:0]            tag_q, tag_d;

  logic [CNTW-1:0]            prefix [NUM_LANES];
  logic [CNTW-1:0]            run_cnt;
  logic [NUM_LANES-1:0]       emitted;
  logic [OUT_LANES-1:0]       pk_mask;
  logic [OUT_LANES*DATAW-1:0] pk_data;
  logic [OUT_LANES*IDXW-1:0]  pk_idx;
  logic                       pk_eop;
  logic                       sending;
  logic                       accept;

  // prefix[i] = number of pending lanes below lane i, i.e. the slot lane i lands in.
  always_comb begin
    run_cnt = '0;
    emitted = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      prefix[i]  = run_cnt;
      emitted[i] = rem_q[i] && (run_cnt < CNTW'(OUT_LANES));
      run_cnt    = run_cnt + CNTW'(rem_q[i]);
    end
  end

  always_comb begin
    pk_mask = '0;
    pk_data = '0;
    pk_idx  = '0;
    for (int s = 0; s < OUT_LANES; s++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (emitted[i] && (prefix[i] == CNTW'(s))) begin
          pk_mask[s]                = 1'b1;
          pk_data[s*DATAW +: DATAW] = data_q[i*DATAW +: DATAW];
          pk_idx[s*IDXW +: IDXW]    = IDXW'(i);
        end
      end
    end
    pk_eop = ((rem_q & ~emitted) == '0);
  end

  assign sending       = (state_q == SEND);
  assign bus.valid_out = sending;
  assign bus.mask_out  = sending ? pk_mask : '0;
  assign bus.data_out  = sending ? pk_data : '0;
  assign bus.idx_out   = sending ? pk_idx  : '0;
  assign bus.tag_out   = sending ? tag_q   : '0;
  assign bus.eop_out   = sending & pk_eop;

  // Final-batch handshake frees the slot on the same edge, so the next request can chain in.
  assign bus.ready_in  = reset_n & (!sending | (pk_eop & bus.ready_out));
  assign accept        = bus.valid_in & bus.ready_in;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    tag_d   = tag_q;

    if (sending && bus.ready_out) begin
      rem_d = rem_q & ~emitted;
      if (pk_eop) begin
        state_d = IDLE;
      end
    end

    if (accept) begin
      rem_d   = bus.mask_in;
      tag_d   = bus.tag_in;
      state_d = SEND;
      for (int i = 0; i < NUM_LANES; i++) begin
        data_d[i*DATAW +: DATAW] = bus.mask_in[i] ? bus.data_in[i*DATAW +: DATAW] : '0;
      end
`ifdef LANE_PACKER_SKIP_EMPTY_EN
      if (bus.mask_in == '0) begin
        state_d = IDLE;
      end
`else
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end
endmodule
